// File: rtl/regfile_write_sched_if.sv
// Write-port bundle of the register-file write scheduler: ALU and memory
// writeback handshakes, issue/hazard scoreboard access and the registered
// register-file write port.
interface regfile_write_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;

  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_reg;
  logic [ADDR_W-1:0] q_reg1;
  logic [ADDR_W-1:0] q_reg2;
  logic              q_busy1;
  logic              q_busy2;

  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              init_done;

  // Writeback stage / hazard unit side
  modport master (
    output a_valid, a_reg, a_data,
    input  a_ready,
    output m_valid, m_reg, m_data,
    input  m_ready,
    output iss_valid, iss_reg, q_reg1, q_reg2,
    input  q_busy1, q_busy2,
    input  RegWrite, write_reg, write_data, init_done
  );

  // Scheduler side
  modport slave (
    input  a_valid, a_reg, a_data,
    output a_ready,
    input  m_valid, m_reg, m_data,
    output m_ready,
    input  iss_valid, iss_reg, q_reg1, q_reg2,
    output q_busy1, q_busy2,
    output RegWrite, write_reg, write_data, init_done
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: clears the register file after reset,
// then round-robin arbitrates the ALU (A) and memory (M) writeback paths onto
// the single registered write port and tracks pending writes for hazards.
module regfile_write_sched #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_sched_if.slave bus
);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {GRANT_A, GRANT_M} grant_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  grant_t              last_q, last_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic              run_ok;
  logic              grant_a, grant_m;
  logic              xfer_a, xfer_m, xfer;
  logic [ADDR_W-1:0] xfer_reg;
  logic [DATA_W-1:0] xfer_data;

  // Arbitration: grant depends only on the valids and the last winner
  always_comb begin
    run_ok    = (state_q == S_RUN) && !reset;
    grant_a   = bus.a_valid && (!bus.m_valid || (last_q == GRANT_M));
    grant_m   = bus.m_valid && !grant_a;
    xfer_a    = run_ok && grant_a;
    xfer_m    = run_ok && grant_m;
    xfer      = xfer_a || xfer_m;
    xfer_reg  = xfer_a ? bus.a_reg  : bus.m_reg;
    xfer_data = xfer_a ? bus.a_data : bus.m_data;
  end

  assign bus.a_ready    = xfer_a;
  assign bus.m_ready    = xfer_m;
  assign bus.q_busy1    = sb_q[bus.q_reg1];
  assign bus.q_busy2    = sb_q[bus.q_reg2];
  assign bus.RegWrite   = regwrite_q;
  assign bus.write_reg  = wreg_q;
  assign bus.write_data = wdata_q;
  assign bus.init_done  = (state_q == S_RUN) && !reset;

  // Next-state: clear sweep in INIT, write-port and scoreboard update in RUN
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    sb_d       = sb_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      S_INIT: begin
        regwrite_d = 1'b1;
        wreg_d     = cnt_q;
        wdata_d    = '0;
        cnt_d      = cnt_q + 1'b1;
        sb_d       = '0;
        if (cnt_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer) begin
          // register 0 is accepted but never written
          regwrite_d     = (xfer_reg != '0);
          wreg_d         = xfer_reg;
          wdata_d        = xfer_data;
          last_d         = xfer_a ? GRANT_A : GRANT_M;
          sb_d[xfer_reg] = 1'b0;
        end
        // applied after the clear so a new producer stays pending
        if (bus.iss_valid && (bus.iss_reg != '0)) sb_d[bus.iss_reg] = 1'b1;
        sb_d[0] = 1'b0;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      last_q     <= GRANT_M;
      cnt_q      <= '0;
      sb_q       <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      sb_q       <= sb_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: clear sweep, arbitration, write
// latency, register-0 suppression, scoreboard and reset-restart behaviour.
module tb_regfile_write_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [31:0] rf [32];

  regfile_write_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_sched #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file model; reset fills it with garbage so the sweep is visible
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_BEEF;
    end else if (bus.RegWrite) begin
      rf[bus.write_reg] <= bus.write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_reg = '0; bus.a_data = '0;
    bus.m_valid = 1'b1; bus.m_reg = '0; bus.m_data = '0;
    bus.iss_valid = 1'b0; bus.iss_reg = '0;
    bus.q_reg1 = 5'd3; bus.q_reg2 = '0;

    // 1: reset then clear sweep
    repeat (2) tick();
    check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_ready", 64'({bus.a_ready, bus.m_ready}), 64'd0);
    reset = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd3;
    #1;
    check("init_c1_ready", 64'({bus.a_ready, bus.m_ready}), 64'd0);
    check("init_c1_regwrite", 64'(bus.RegWrite), 64'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      check("sweep_port", 64'({bus.RegWrite, bus.write_reg, bus.write_data}),
            64'({1'b1, 5'(i), 32'h0}));
      check("sweep_init_done", 64'(bus.init_done), 64'(i == 31));
      if (i < 31) begin
        check("sweep_ready", 64'({bus.a_ready, bus.m_ready}), 64'd0);
        check("sweep_busy", 64'(bus.q_busy1), 64'd0);
      end
    end
    bus.iss_valid = 1'b0;

    // 4: tie arbitration, first tie to A then alternating
    bus.a_reg = 5'd1; bus.a_data = 32'h11;
    bus.m_reg = 5'd2; bus.m_data = 32'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("tie_a_ready", 64'(bus.a_ready), 64'(k % 2 == 0));
      check("tie_m_ready", 64'(bus.m_ready), 64'(k % 2 == 1));
      tick();
      check("tie_port", 64'({bus.RegWrite, bus.write_reg, bus.write_data}),
            (k % 2 == 0) ? 64'({1'b1, 5'd1, 32'h11}) : 64'({1'b1, 5'd2, 32'h22}));
    end
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    tick();
    check("idle_hold", 64'({bus.RegWrite, bus.write_reg, bus.write_data}),
          64'({1'b0, 5'd2, 32'h22}));
    bad = 0;
    for (int r = 0; r < 32; r++)
      if (r != 1 && r != 2 && rf[r] != 32'h0) bad++;
    check("sweep_rf_zero", 64'(bad), 64'd0);
    check("rf1", 64'(rf[1]), 64'h11);
    check("rf2", 64'(rf[2]), 64'h22);

    // 3: single ALU request, then single memory request
    bus.a_valid = 1'b1; bus.a_reg = 5'd5; bus.a_data = 32'h1234_5678;
    #1;
    check("a_only_ready", 64'({bus.a_ready, bus.m_ready}), 64'b10);
    tick();
    bus.a_valid = 1'b0;
    check("a_only_port", 64'({bus.RegWrite, bus.write_reg, bus.write_data}),
          64'({1'b1, 5'd5, 32'h1234_5678}));
    tick();
    check("rf5", 64'(rf[5]), 64'h1234_5678);
    bus.m_valid = 1'b1; bus.m_reg = 5'd6; bus.m_data = 32'h66;
    #1;
    check("m_only_ready", 64'({bus.a_ready, bus.m_ready}), 64'b01);
    tick();
    bus.m_valid = 1'b0;
    check("m_only_port", 64'({bus.RegWrite, bus.write_reg, bus.write_data}),
          64'({1'b1, 5'd6, 32'h66}));

    // 5: scoreboard set, clear, and same-cycle set-over-clear
    bus.q_reg1 = 5'd8; bus.q_reg2 = 5'd9;
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd8;
    #1;
    check("sb_before_set", 64'(bus.q_busy1), 64'd0);
    tick();
    bus.iss_valid = 1'b0;
    check("sb_set", 64'(bus.q_busy1), 64'd1);
    check("sb_other", 64'(bus.q_busy2), 64'd0);
    bus.m_valid = 1'b1; bus.m_reg = 5'd8; bus.m_data = 32'h88;
    #1;
    check("sb_clr_ready", 64'(bus.m_ready), 64'd1);
    tick();
    bus.m_valid = 1'b0;
    check("sb_cleared", 64'(bus.q_busy1), 64'd0);
    bus.iss_valid = 1'b1;
    tick();
    check("sb_reset_again", 64'(bus.q_busy1), 64'd1);
    bus.a_valid = 1'b1; bus.a_reg = 5'd8; bus.a_data = 32'h99;
    #1;
    check("sb_same_ready", 64'(bus.a_ready), 64'd1);
    tick();
    bus.a_valid = 1'b0; bus.iss_valid = 1'b0;
    check("sb_set_wins", 64'(bus.q_busy1), 64'd1);
    check("sb_same_port", 64'({bus.RegWrite, bus.write_reg}), 64'({1'b1, 5'd8}));

    // 6: register 0 accepted but never written, never busy
    bus.a_valid = 1'b1; bus.a_reg = 5'd0; bus.a_data = 32'hFFFF_FFFF;
    bus.iss_valid = 1'b1; bus.iss_reg = 5'd0; bus.q_reg2 = 5'd0;
    #1;
    check("r0_ready", 64'(bus.a_ready), 64'd1);
    tick();
    bus.a_valid = 1'b0; bus.iss_valid = 1'b0;
    check("r0_regwrite", 64'(bus.RegWrite), 64'd0);
    check("r0_busy", 64'(bus.q_busy2), 64'd0);
    tick();
    check("rf0", 64'(rf[0]), 64'h0);

    // 2: ready gated by reset, then reset mid-sweep restarts at 0
    bus.a_valid = 1'b1; bus.a_reg = 5'd4; bus.a_data = 32'h44;
    reset = 1'b1;
    #1;
    check("rst_run_ready", 64'(bus.a_ready), 64'd0);
    check("rst_run_done", 64'(bus.init_done), 64'd0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_sweep_reg", 64'({bus.RegWrite, bus.write_reg}), 64'({1'b1, 5'd9}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("restart_regwrite", 64'(bus.RegWrite), 64'd0);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (!bus.RegWrite || bus.write_reg != 5'(i) || bus.write_data != 32'h0) bad++;
      if (i < 31 && (bus.init_done || bus.a_ready)) bad++;
    end
    check("restart_sweep", 64'(bad), 64'd0);
    check("restart_done", 64'(bus.init_done), 64'd1);
    check("restart_ready", 64'(bus.a_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
Write-port controller for the 32x32 register file. It shares the single write port (RegWrite / write_reg / write_data) between two writeback requesters: the ALU path (A) and the load/memory path (M). It also clears the register file after reset and keeps a pending-write scoreboard that the hazard logic queries. It sits between the writeback stage and the register file's write inputs.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
NUM_REGS, 32, number of registers (2**ADDR_W)
CLEAR_ON_RESET, 1, 1 = sweep all registers to 0 after reset; 0 = skip the sweep

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
a_valid  in  1  ALU writeback request
a_ready  out  1  ALU request accepted this cycle
a_reg  in  ADDR_W  ALU destination register
a_data  in  DATA_W  ALU result
m_valid  in  1  memory writeback request
m_ready  out  1  memory request accepted this cycle
m_reg  in  ADDR_W  memory destination register
m_data  in  DATA_W  load data
iss_valid  in  1  an instruction is issued that will write iss_reg
iss_reg  in  ADDR_W  destination register of the issued instruction
q_reg1  in  ADDR_W  hazard query, source register 1
q_reg2  in  ADDR_W  hazard query, source register 2
q_busy1  out  1  q_reg1 has a pending write (combinational)
q_busy2  out  1  q_reg2 has a pending write (combinational)
RegWrite  out  1  register-file write enable (registered)
write_reg  out  ADDR_W  register-file write index (registered)
write_data  out  DATA_W  register-file write data (registered)
init_done  out  1  high once the block is in RUN

Behaviour:
- One clock domain, clk. Synchronous active-high reset.
- Reset values:
  - FSM = INIT if CLEAR_ON_RESET=1, else RUN.
  - RegWrite=0, write_reg=0, write_data=0, init_done=0.
  - Clear counter=0, all scoreboard bits=0, last_grant=M.
  - a_ready and m_ready are 0 while reset is high.
- State INIT:
  - Each cycle drive RegWrite=1, write_reg=cnt, write_data=0; increment cnt.
  - After cnt=NUM_REGS-1 is written, go to RUN. INIT lasts exactly NUM_REGS cycles.
  - a_ready=m_ready=0 throughout INIT. iss_valid is ignored and the scoreboard is held at 0.
  - Reset asserted mid-INIT restarts the sweep at cnt=0.
- State RUN:
  - init_done=1 from the first RUN cycle, including when CLEAR_ON_RESET=0 (RUN starts on the cycle after reset deasserts).
  - Arbitration:
    - Only one valid → that requester is granted.
    - Both valid → the requester not granted last time wins (round-robin). last_grant updates only on a transfer.
    - First tie after reset goes to A.
    - x_ready = RUN and granted. Grant depends only on the valids, not on the data.
  - Transfer when x_valid && x_ready. Requesters hold reg/data stable until they see ready.
  - Latency is 1 cycle: on the next edge, RegWrite=1, write_reg=x_reg, write_data=x_data.
  - No transfer → RegWrite=0 on the next cycle; write_reg and write_data keep their last values.
  - A transfer with x_reg=0 is accepted (ready=1) but produces RegWrite=0, so register 0 is never written.
  - Throughput is one write per cycle. The loser is stalled with ready=0 until it is granted.
- Scoreboard (NUM_REGS bits):
  - iss_valid with iss_reg≠0 sets bit[iss_reg] on the next edge.
  - An accepted transfer to register r clears bit[r] on the next edge.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is outstanding).
  - Bit 0 is always 0.
  - q_busyN = bit[q_regN]; shows the updated state from the cycle after the set or clear edge.
- Register-file write-port timing: a register written via RegWrite at edge k is readable by the register file from edge k onward. No bypass inside this block.

Test Plan:
1. Reset for 2 cycles, CLEAR_ON_RESET=1 → RegWrite=1 for 32 consecutive cycles with write_reg 0..31 and write_data=0; ready stays low; init_done rises on cycle 33; afterwards every register reads 0.
2. Reset at INIT cnt=10 for 1 cycle → sweep restarts at write_reg=0 and again takes 32 cycles.
3. RUN, a_valid only with a_reg=5, a_data=0x12345678 → a_ready=1 the same cycle; next cycle RegWrite=1, write_reg=5, write_data=0x12345678; register 5 reads 0x12345678.
4. a_valid and m_valid held high for 4 cycles (a_reg=1, m_reg=2) → grants alternate A,M,A,M; write_reg sequence 1,2,1,2 with no idle cycle.
5. iss_valid with iss_reg=8, then q_reg1=8 → q_busy1=1; m transfer to register 8 → q_busy1=0 the following cycle. Same-cycle iss_reg=8 and transfer to 8 → q_busy1 stays 1.
6. a_valid with a_reg=0, a_data=0xFFFFFFFF → a_ready=1, RegWrite stays 0, register 0 still reads 0; iss_reg=0 never sets busy.
